// File: rtl/sp_ram_arb_pkg.sv
// Shared types and defaults for the two-port single-port-RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: port identifiers, the RAM request bundle and default widths/limits.
package sp_ram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_WAIT   = 8;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_BUS  = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic                        we;
        logic [DEF_DATA_WIDTH/8-1:0] be;
        logic [DEF_DATA_WIDTH-1:0]   wdata;
    } ram_req_t;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// PULP-style req/gnt/rvalid memory port bundle.
// Latency: n/a (wiring only).
// Backpressure: requester holds addr/we/be/wdata while req is high and gnt low.
// Modports: master = requester side, slave = arbiter side.
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = sp_ram_arb_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = sp_ram_arb_pkg::DEF_DATA_WIDTH
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sp_ram_arb_select.sv
// Grant decision between the core port (0) and the bus port (1).
// Latency: combinational grant from req and registered arbitration state.
// Backpressure: the losing requester simply sees gnt low and keeps req up.
// Ports: clk, rst_i, i_req0/i_req1 in; o_gnt0/o_gnt1 out (one-hot or zero).
// Build option SP_RAM_ARB_FIXED_PRIO_EN: fixed priority to port 0 with a
// starvation counter for port 1; otherwise round-robin on the last grant.
module sp_ram_arb_select
    import sp_ram_arb_pkg::*;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
)
`endif
(
    input  logic clk,
    input  logic rst_i,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    localparam int             CW    = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] r_wait;
    logic          w_starved;

    assign w_starved = (r_wait == LIMIT);
    // Port 1 only wins a tie once it has waited MAX_WAIT cycles.
    assign o_gnt1    = i_req1 && (!i_req0 || w_starved);
    assign o_gnt0    = i_req0 && !o_gnt1;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_wait <= '0;
        end else if (!i_req1 || o_gnt1) begin
            r_wait <= '0;
        end else if (!w_starved) begin
            r_wait <= r_wait + 1'b1;
        end
    end
`else
    port_id_e r_last_gnt;

    // On a tie the port that did not win last time is served.
    assign o_gnt0 = i_req0 && (!i_req1 || (r_last_gnt == PORT_BUS));
    assign o_gnt1 = i_req1 && (!i_req0 || (r_last_gnt == PORT_CORE));

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_last_gnt <= PORT_BUS;   // port 0 takes the first tie
        end else if (o_gnt0) begin
            r_last_gnt <= PORT_CORE;
        end else if (o_gnt1) begin
            r_last_gnt <= PORT_BUS;
        end
    end
`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares the single port of sp_ram_wrap between the core LSU (p0) and the AXI/debug bridge (p1).
// Latency: gnt same cycle when uncontended; rvalid exactly one cycle after gnt.
// Backpressure: loser of a tie sees gnt low and must hold its request stable.
// Ports: clk, rst_i; p0/p1 request interfaces (slave modport);
//        ram_en_o/addr/we/be/wdata out and ram_rdata_i in toward the RAM wrapper.
// Build option SP_RAM_ARB_FIXED_PRIO_EN selects fixed priority + starvation limit.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                    clk,
    input  logic                    rst_i,
    sp_ram_arbiter_if.slave         p0,
    sp_ram_arbiter_if.slave         p1,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    if (MAX_WAIT < 1) begin : g_max_wait_chk
        $error("sp_ram_arbiter: MAX_WAIT must be at least 1");
    end

    logic w_gnt0;
    logic w_gnt1;
    logic w_any_gnt;

    logic                  r_resp_valid;
    port_id_e              r_resp_port;
    logic                  r_resp_read;
    logic [ADDR_WIDTH-1:0] r_hold_addr;

    sp_ram_arb_select
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        #(.MAX_WAIT(MAX_WAIT))
`endif
        u_select (
            .clk    (clk),
            .rst_i  (rst_i),
            .i_req0 (p0.req),
            .i_req1 (p1.req),
            .o_gnt0 (w_gnt0),
            .o_gnt1 (w_gnt1)
        );

    assign w_any_gnt = w_gnt0 || w_gnt1;
    assign p0.gnt    = w_gnt0;
    assign p1.gnt    = w_gnt1;

    // The wrapper zeroes rdata whenever en is low, so a read's response
    // cycle without a new grant re-issues a harmless read of the same word.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (w_gnt0) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = p0.addr;
            ram_we_o    = p0.we;
            ram_be_o    = p0.be;
            ram_wdata_o = p0.wdata;
        end else if (w_gnt1) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = p1.addr;
            ram_we_o    = p1.we;
            ram_be_o    = p1.be;
            ram_wdata_o = p1.wdata;
        end else if (r_resp_valid && r_resp_read) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = r_hold_addr;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_port  <= PORT_CORE;
            r_resp_read  <= 1'b0;
            r_hold_addr  <= '0;
        end else begin
            r_resp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_resp_port <= w_gnt1 ? PORT_BUS : PORT_CORE;
                r_resp_read <= !ram_we_o;
                r_hold_addr <= ram_addr_o;
            end
        end
    end

    // Writes answer with zero data; only the owning port sees the response.
    assign p0.rvalid = r_resp_valid && (r_resp_port == PORT_CORE);
    assign p1.rvalid = r_resp_valid && (r_resp_port == PORT_BUS);
    assign p0.rdata  = (p0.rvalid && r_resp_read) ? ram_rdata_i : '0;
    assign p1.rdata  = (p1.rvalid && r_resp_read) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter with a behavioural RAM and reference model.
// Latency: model expects gnt same cycle, rvalid one cycle later.
// Backpressure: stimulus holds a request stable until the model says it was granted.
module tb_sp_ram_arbiter;
    import sp_ram_arb_pkg::*;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MW = 8;

    typedef logic [120:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_p0 ();
    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_p1 ();

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst_i       (rst),
        .p0          (u_p0),
        .p1          (u_p1),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural sp_ram_wrap: registered read, output forced to 0 when en is low.
    logic [DW-1:0] ram_mem [0:15];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_q <= ram_mem[ram_addr[5:2]];
            end
        end
    end
    assign ram_rdata = ram_en ? ram_q : '0;

    // Stimulus and reference model state.
    ram_req_t      drv [2];
    logic          drv_req [2];
    logic [DW-1:0] ref_mem [0:15];
    int            m_last, m_wait, m_win, pport;
    bit            pv, pread;
    logic [DW-1:0] pdata;
    logic [AW-1:0] paddr;

    int   n_err = 0;
    int   n_checks = 0;
    vec_t exp_v, obs_v;

    task automatic apply();
        u_p0.req = drv_req[0]; u_p0.addr = drv[0].addr; u_p0.we = drv[0].we;
        u_p0.be  = drv[0].be;  u_p0.wdata = drv[0].wdata;
        u_p1.req = drv_req[1]; u_p1.addr = drv[1].addr; u_p1.we = drv[1].we;
        u_p1.be  = drv[1].be;  u_p1.wdata = drv[1].wdata;
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [BW-1:0] be,
                            input logic [DW-1:0] wdata);
        drv_req[p]    = req;
        drv[p].we     = we;
        drv[p].addr   = addr;
        drv[p].be     = be;
        drv[p].wdata  = wdata;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic vec_t pack_obs();
        return {u_p0.gnt, u_p1.gnt, u_p0.rvalid, u_p1.rvalid, u_p0.rdata, u_p1.rdata,
                ram_en, ram_we, ram_addr, ram_be, ram_wdata};
    endfunction

    task automatic model_reset();
        m_last = 1; m_wait = 0; m_win = -1; pv = 0; pread = 0; pport = 0;
        pdata = '0; paddr = '0;
    endtask

    // One cycle of the arbiter as described in words: who wins, what the RAM
    // sees, what response comes out; then advance the model by one cycle.
    task automatic model_cycle(output vec_t e);
        int w;
        logic rv0, rv1, en, we;
        logic [DW-1:0] rd0, rd1, wd;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        if (drv_req[0] && drv_req[1]) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
            w = (m_wait >= MW) ? 1 : 0;
`else
            w = 1 - m_last;
`endif
        end else if (drv_req[0]) w = 0;
        else if (drv_req[1]) w = 1;
        else w = -1;
        rv0 = pv && (pport == 0);
        rv1 = pv && (pport == 1);
        rd0 = (rv0 && pread) ? pdata : '0;
        rd1 = (rv1 && pread) ? pdata : '0;
        en = 0; we = 0; a = '0; be = '0; wd = '0;
        if (w >= 0) begin
            en = 1; we = drv[w].we; a = drv[w].addr; be = drv[w].be; wd = drv[w].wdata;
        end else if (pv && pread) begin
            en = 1; a = paddr;
        end
        e = {(w == 0), (w == 1), rv0, rv1, rd0, rd1, en, we, a, be, wd};
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        if (!drv_req[1] || w == 1) m_wait = 0;
        else if (m_wait < MW) m_wait++;
`endif
        m_win = w;
        if (w >= 0) begin
            m_last = w; pv = 1; pport = w; pread = !drv[w].we; paddr = a;
            pdata  = pread ? ref_mem[a[5:2]] : '0;
            if (!pread)
                for (int b = 0; b < BW; b++)
                    if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            pv = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); apply();
        @(negedge clk);
        obs_v = pack_obs();
        n_checks++;
        if (obs_v !== '0) begin
            n_err++; $display("FAIL reset_state: got %h want 0", obs_v);
        end
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                set_port(0, 1'b1, 1'b0, 15'h0000, 4'hF, '0);
                set_port(1, 1'b1, 1'b0, 15'h0004, 4'hF, '0);
            end else idle();
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL round_robin c%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i < 4) begin
                n_checks++;
                if ({u_p0.gnt, u_p1.gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL rr_alternate c%0d: got %b%b", i, u_p0.gnt, u_p1.gnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) set_port(0, 1'b1, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF);
            if (i == 1) set_port(0, 1'b1, 1'b0, 15'h0010, 4'hF, '0);
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL write_read c%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i == 2) begin
                n_checks++;
                if (u_p0.rdata !== 32'hDEADBEEF || u_p0.rvalid !== 1'b1) begin
                    n_err++; $display("FAIL write_read_data: got %h want deadbeef", u_p0.rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_read_hold();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 0) set_port(1, 1'b1, 1'b0, 15'h0004, 4'hF, '0);
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL read_hold c%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i == 1) begin
                n_checks++;
                if (ram_en !== 1'b1 || ram_we !== 1'b0 || u_p1.rdata !== 32'h22222222) begin
                    n_err++; $display("FAIL read_hold_en: en=%b we=%b rdata=%h want 1 0 22222222",
                                      ram_en, ram_we, u_p1.rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_byte_write();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) set_port(1, 1'b1, 1'b1, 15'h0004, 4'b0010, 32'h0000AB00);
            if (i == 1) set_port(0, 1'b1, 1'b0, 15'h0004, 4'hF, '0);
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL byte_write c%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i == 2) begin
                n_checks++;
                if (u_p0.rdata !== 32'h2222AB22) begin
                    n_err++; $display("FAIL byte_merge: got %h want 2222ab22", u_p0.rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        idle(); set_port(0, 1'b1, 1'b0, 15'h0010, 4'hF, '0); apply();
        @(negedge clk);
        model_cycle(exp_v); obs_v = pack_obs();
        n_checks++;
        if (obs_v !== exp_v) begin
            n_err++; $display("FAIL reset_mid_grant: got %h want %h", obs_v, exp_v);
        end
        @(posedge clk); #1;
        idle(); apply(); rst = 1'b1; model_reset();
        @(negedge clk);
        obs_v = pack_obs();
        n_checks++;
        if (obs_v !== '0) begin
            n_err++; $display("FAIL reset_mid_quiet: got %h want 0", obs_v);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_port(0, 1'b1, 1'b0, 15'h0008, 4'hF, '0);
                set_port(1, 1'b1, 1'b0, 15'h000C, 4'hF, '0);
            end else idle();
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL reset_mid_after c%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i == 1) begin
                n_checks++;
                if (u_p0.gnt !== 1'b1 || u_p1.gnt !== 1'b0) begin
                    n_err++; $display("FAIL post_reset_tie: got gnt0=%b gnt1=%b want 1 0",
                                      u_p0.gnt, u_p1.gnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                // A request that lost stays up with unchanged fields.
                if (!(drv_req[p] && m_win != p)) begin
                    set_port(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             AW'($urandom_range(0, 15) << 2), BW'($urandom_range(0, 15)),
                             $urandom);
                end
            end
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL random c%0d: got %h want %h", i, obs_v, exp_v);
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        for (int i = -1; i < 27; i++) begin
            if (i < 0) idle();
            else begin
                set_port(0, 1'b1, 1'b0, 15'h0000, 4'hF, '0);
                set_port(1, 1'b1, 1'b0, 15'h0004, 4'hF, '0);
            end
            apply();
            @(negedge clk);
            model_cycle(exp_v); obs_v = pack_obs();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL fixed_prio c%0d: got %h want %h", i, obs_v, exp_v);
            end
            if (i >= 0) begin
                n_checks++;
                if (u_p1.gnt !== ((i % 9) == 8)) begin
                    n_err++; $display("FAIL starvation c%0d: got gnt1=%b", i, u_p1.gnt);
                end
            end
            @(posedge clk); #1;
        end
        idle();
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom;
            ram_mem[k] = ref_mem[k];
        end
        ref_mem[0] = 32'h11111111; ram_mem[0] = 32'h11111111;
        ref_mem[1] = 32'h22222222; ram_mem[1] = 32'h22222222;
        ram_q = '0;
        model_reset();
        rst = 1'b1; idle(); apply();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_write_read();
        test_read_hold();
        test_byte_write();
        test_reset_mid();
        test_random();
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
